// File: rtl/ultra_ranging_module.sv
// Ultrasonic range-finder front end: periodic trigger, echo timing in us, conversion to mm.
// Define ULTRA_MEDIAN3_EN to pass valid results through a 3-tap median filter.
module ultra_ranging_module #(
  parameter int CLK_MHZ    = 25,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        En,
  input  logic        ECHO,
  output logic        TRIG,
  output logic [15:0] Ultra_Dat,
  output logic        Ultra_Rdy,
  output logic        Ultra_Err
);
  localparam int PSW = $clog2(CLK_MHZ) + 1;
  localparam int CW  = $clog2(TIMEOUT_US + 1);
  localparam int PRW = $clog2(PERIOD_US + TRIG_US + 2 * TIMEOUT_US + 4);
  localparam int PW  = CW + 14;
  localparam logic [13:0] MM_COEF = 14'd11239;

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_CALC, S_HOLDOFF} state_t;
  state_t state, state_nxt;

  logic           echo_s1, echo_s2, echo_s3;
  logic           rise, fall, tick;
  logic [PSW-1:0] presc;
  logic [CW-1:0]  cnt;
  logic [PRW-1:0] period_cnt;
  logic           go_calc, tout_nxt;
  logic [PW-1:0]  product_p1;
  logic           tout_p1, vld_p1;

  // 11239/65536 mm per us, truncated
  function automatic logic [15:0] us_to_mm(input logic [PW-1:0] product);
    return 16'(product >> 16);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) {echo_s3, echo_s2, echo_s1} <= '0;
    else     {echo_s3, echo_s2, echo_s1} <= {echo_s2, echo_s1, ECHO};
  end

  assign rise = echo_s2 & ~echo_s3;
  assign fall = ~echo_s2 & echo_s3;
  assign tick = (presc == PSW'(CLK_MHZ - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              presc <= '0;
    else if ((state == S_IDLE && En) || tick) presc <= '0;
    else                                  presc <= presc + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // cnt serves as TRIG width, rise timeout and echo width counter; it restarts on every state change
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      period_cnt <= '0;
    end else begin
      if (state_nxt != state)
        cnt <= '0;
      else if (tick && (state == S_TRIG || state == S_WAIT_RISE || (state == S_MEASURE && echo_s2)))
        cnt <= cnt + 1'b1;
      if (state_nxt == S_TRIG && state != S_TRIG)
        period_cnt <= '0;
      else if (tick && state != S_IDLE)
        period_cnt <= period_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    TRIG      = 1'b0;
    go_calc   = 1'b0;
    tout_nxt  = 1'b0;
    case (state)
      S_IDLE: if (En) state_nxt = S_TRIG;
      S_TRIG: begin
        TRIG = 1'b1;
        if (tick && cnt == CW'(TRIG_US - 1)) state_nxt = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (rise) state_nxt = S_MEASURE;
        else if (tick && cnt == CW'(TIMEOUT_US - 1)) begin
          go_calc  = 1'b1;
          tout_nxt = 1'b1;
        end
      end
      S_MEASURE: begin
        if (cnt == CW'(TIMEOUT_US)) begin
          go_calc  = 1'b1;
          tout_nxt = 1'b1;
        end else if (fall) go_calc = 1'b1;
      end
      S_CALC: state_nxt = S_HOLDOFF;
      S_HOLDOFF: if (tick && period_cnt >= PRW'(PERIOD_US - 1)) state_nxt = En ? S_TRIG : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (go_calc) state_nxt = S_CALC;
  end

  // Stage p1: multiply register
  always_ff @(posedge CLK) begin
    if (go_calc) begin
      product_p1 <= PW'(cnt) * PW'(MM_COEF);
      tout_p1    <= tout_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld_p1 <= 1'b0;
    else     vld_p1 <= go_calc;
  end

`ifdef ULTRA_MEDIAN3_EN
  logic [15:0] mm_p2, hist0, hist1;
  logic        tout_p2, vld_p2;
  logic [1:0]  hist_n;

  function automatic logic [15:0] median3(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
    logic [15:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo)      return lo;
    else if (c > hi) return hi;
    else             return c;
  endfunction

  // Stage p2: converted value ahead of the median
  always_ff @(posedge CLK) begin
    if (vld_p1) begin
      mm_p2   <= us_to_mm(product_p1);
      tout_p2 <= tout_p1;
    end
    if (vld_p2 && !tout_p2) begin
      hist1 <= hist0;
      hist0 <= mm_p2;
    end
  end

  // Output stage: timeouts bypass the filter and stay out of the history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p2    <= 1'b0;
      hist_n    <= '0;
      Ultra_Rdy <= 1'b0;
      Ultra_Err <= 1'b0;
      Ultra_Dat <= '0;
    end else begin
      vld_p2    <= vld_p1;
      Ultra_Rdy <= vld_p2;
      if (vld_p2) begin
        Ultra_Err <= tout_p2;
        if (tout_p2) Ultra_Dat <= 16'hFFFF;
        else begin
          Ultra_Dat <= (hist_n == 2'd2) ? median3(mm_p2, hist0, hist1) : mm_p2;
          if (hist_n != 2'd2) hist_n <= hist_n + 1'b1;
        end
      end
    end
  end
`else
  // Output stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Ultra_Rdy <= 1'b0;
      Ultra_Err <= 1'b0;
      Ultra_Dat <= '0;
    end else begin
      Ultra_Rdy <= vld_p1;
      if (vld_p1) begin
        Ultra_Err <= tout_p1;
        Ultra_Dat <= tout_p1 ? 16'hFFFF : us_to_mm(product_p1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ultra_ranging_module.sv
// Bench for ultra_ranging_module using a scaled timing setup (2 MHz, short period) to stay fast.
// Expected distances come from plain arithmetic on the echo width plus a median history model.
module tb_ultra_ranging_module;
  localparam int CLK_MHZ    = 2;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 6000;
  localparam int PERIOD_US  = 2000;
  localparam int RISE_BOUND = (PERIOD_US + 2 * TIMEOUT_US + 100) * CLK_MHZ;
`ifdef ULTRA_MEDIAN3_EN
  localparam int MED = 1;
`else
  localparam int MED = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST, En, ECHO, TRIG;
  logic [15:0] Ultra_Dat;
  logic        Ultra_Rdy, Ultra_Err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_rise = 0;
  int hist[$];

  ultra_ranging_module #(
    .CLK_MHZ(CLK_MHZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US), .PERIOD_US(PERIOD_US)
  ) dut (
    .CLK(CLK), .RST(RST), .En(En), .ECHO(ECHO), .TRIG(TRIG),
    .Ultra_Dat(Ultra_Dat), .Ultra_Rdy(Ultra_Rdy), .Ultra_Err(Ultra_Err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int to_mm(input int us);
    longint p;
    p = longint'(us) * 64'd11239;
    return int'(p / 65536);
  endfunction

  // Expected output for a valid raw value; updates the history of valid results
  function automatic int model_valid(input int raw);
    int r;
    int s[$];
    r = raw;
    if (MED != 0 && hist.size() >= 2) begin
      s = {hist[0], hist[1], raw};
      s.sort();
      r = s[1];
    end
    hist.push_back(raw);
    if (hist.size() > 2) void'(hist.pop_front());
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_trig_rise(output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < RISE_BOUND; i++) begin
      @(negedge CLK);
      if (TRIG === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_trig_fall(output int width);
    width = 1;
    while (width <= 4 * TRIG_US * CLK_MHZ) begin
      @(negedge CLK);
      if (TRIG !== 1'b1) break;
      width++;
    end
  endtask

  task automatic wait_rdy(input int bound, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Ultra_Rdy !== 1'b1 && n < bound);
    if (Ultra_Rdy !== 1'b1) n = -1;
  endtask

  task automatic echo_pulse(input int delay_us, input int width_us, output int lat);
    tick(delay_us * CLK_MHZ);
    ECHO = 1'b1;
    tick(width_us * CLK_MHZ);
    ECHO = 1'b0;
    wait_rdy(64, lat);
  endtask

  task automatic test_reset;
    RST = 1'b1; En = 1'b0; ECHO = 1'b0;
    tick(3);
    vectors++; if (TRIG !== 1'b0) begin miscompares++; $display("FAIL reset_trig: got %b expected 0", TRIG); end
    vectors++; if (Ultra_Dat !== 16'h0000) begin miscompares++; $display("FAIL reset_dat: got %h expected 0000", Ultra_Dat); end
    vectors++; if (Ultra_Rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b expected 0", Ultra_Rdy); end
    vectors++; if (Ultra_Err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", Ultra_Err); end
    RST = 1'b0;
    hist.delete();
    tick(40);
    vectors++; if (TRIG !== 1'b0) begin miscompares++; $display("FAIL idle_no_trig: got %b expected 0", TRIG); end
  endtask

  task automatic test_basic;
    int w, lat, exp;
    En = 1'b1;
    @(negedge CLK);
    vectors++; if (TRIG !== 1'b1) begin miscompares++; $display("FAIL trig_start: got %b expected 1", TRIG); end
    last_rise = cyc;
    wait_trig_fall(w);
    vectors++; if (w != TRIG_US * CLK_MHZ) begin miscompares++; $display("FAIL trig_width: got %0d expected %0d", w, TRIG_US * CLK_MHZ); end
    echo_pulse(50, 1000, lat);
    vectors++; if (lat != 4 + MED) begin miscompares++; $display("FAIL rdy_latency: got %0d expected %0d", lat, 4 + MED); end
    exp = model_valid(to_mm(1000));
    vectors++; if (Ultra_Dat !== 16'(exp)) begin miscompares++; $display("FAIL basic_dat: got %0d expected %0d", Ultra_Dat, exp); end
    vectors++; if (Ultra_Err !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b expected 0", Ultra_Err); end
    @(negedge CLK);
    vectors++; if (Ultra_Rdy !== 1'b0) begin miscompares++; $display("FAIL rdy_width: got %b expected 0", Ultra_Rdy); end
  endtask

  task automatic test_sequence;
    bit ok;
    int at, w, lat, exp;
    wait_trig_rise(ok, at);
    vectors++; if (!ok || at - last_rise != PERIOD_US * CLK_MHZ) begin miscompares++; $display("FAIL period: got %0d expected %0d", at - last_rise, PERIOD_US * CLK_MHZ); end
    wait_trig_fall(w);
    echo_pulse(50, 5830, lat);
    exp = model_valid(to_mm(5830));
    vectors++; if (lat < 0 || Ultra_Dat !== 16'(exp)) begin miscompares++; $display("FAIL seq_5830: got %0d expected %0d", Ultra_Dat, exp); end
    wait_trig_rise(ok, at);
    wait_trig_fall(w);
    echo_pulse(30, 200, lat);
    exp = model_valid(to_mm(200));
    vectors++; if (lat < 0 || Ultra_Dat !== 16'(exp)) begin miscompares++; $display("FAIL seq_200: got %0d expected %0d", Ultra_Dat, exp); end
    vectors++; if (Ultra_Err !== 1'b0) begin miscompares++; $display("FAIL seq_err: got %b expected 0", Ultra_Err); end
  endtask

  task automatic test_timeout;
    bit ok;
    int at, w, n, lat, exp, extra;
    wait_trig_rise(ok, at);
    wait_trig_fall(w);
    wait_rdy((TIMEOUT_US + 20) * CLK_MHZ, n);
    vectors++; if (n < TIMEOUT_US * CLK_MHZ || n > (TIMEOUT_US + 3) * CLK_MHZ) begin miscompares++; $display("FAIL timeout_time: got %0d expected about %0d", n, TIMEOUT_US * CLK_MHZ); end
    vectors++; if (Ultra_Dat !== 16'hFFFF) begin miscompares++; $display("FAIL timeout_dat: got %h expected ffff", Ultra_Dat); end
    vectors++; if (Ultra_Err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b expected 1", Ultra_Err); end
    extra = 0;
    ok = 1'b0;
    for (int i = 0; i < RISE_BOUND; i++) begin
      @(negedge CLK);
      if (Ultra_Rdy === 1'b1) extra++;
      if (TRIG === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++; if (!ok || extra != 0) begin miscompares++; $display("FAIL single_strobe: got %0d extra strobes, trig %b, expected 0 and 1", extra, ok); end
    wait_trig_fall(w);
    echo_pulse(50, 1000, lat);
    exp = model_valid(to_mm(1000));
    vectors++; if (lat < 0 || Ultra_Dat !== 16'(exp)) begin miscompares++; $display("FAIL recover_dat: got %0d expected %0d", Ultra_Dat, exp); end
    vectors++; if (Ultra_Err !== 1'b0) begin miscompares++; $display("FAIL recover_err: got %b expected 0", Ultra_Err); end
  endtask

  task automatic test_stuck_high;
    bit ok;
    int at, w, n;
    ECHO = 1'b1;
    wait_trig_rise(ok, at);
    wait_trig_fall(w);
    tick(300 * CLK_MHZ);
    ECHO = 1'b0;
    wait_rdy((TIMEOUT_US + 20) * CLK_MHZ, n);
    if (n >= 0) n = n + 300 * CLK_MHZ;
    vectors++; if (n < TIMEOUT_US * CLK_MHZ || n > (TIMEOUT_US + 3) * CLK_MHZ) begin miscompares++; $display("FAIL stale_time: got %0d expected about %0d", n, TIMEOUT_US * CLK_MHZ); end
    vectors++; if (Ultra_Dat !== 16'hFFFF || Ultra_Err !== 1'b1) begin miscompares++; $display("FAIL stale_result: got %h/%b expected ffff/1", Ultra_Dat, Ultra_Err); end
  endtask

  task automatic test_random;
    bit ok;
    int at, prev, w, d, tw, lat, exp;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      do w = int'($urandom_range(1500, 100)); while (to_mm(w) != to_mm(w - 1));
      d = int'($urandom_range(200, 5));
      wait_trig_rise(ok, at);
      if (prev >= 0) begin
        vectors++; if (!ok || at - prev != PERIOD_US * CLK_MHZ) begin miscompares++; $display("FAIL rand_period: got %0d expected %0d", at - prev, PERIOD_US * CLK_MHZ); end
      end
      prev = at;
      wait_trig_fall(tw);
      echo_pulse(d, w, lat);
      exp = model_valid(to_mm(w));
      vectors++; if (lat != 4 + MED) begin miscompares++; $display("FAIL rand_latency: got %0d expected %0d", lat, 4 + MED); end
      vectors++; if (Ultra_Dat !== 16'(exp) || Ultra_Err !== 1'b0) begin miscompares++; $display("FAIL rand_dat: width %0d got %0d/%b expected %0d/0", w, Ultra_Dat, Ultra_Err, exp); end
    end
  endtask

  task automatic test_en_drop;
    bit ok;
    int at, w, lat, exp, rises;
    wait_trig_rise(ok, at);
    wait_trig_fall(w);
    tick(20 * CLK_MHZ);
    ECHO = 1'b1;
    tick(200 * CLK_MHZ);
    En = 1'b0;
    tick(300 * CLK_MHZ);
    ECHO = 1'b0;
    wait_rdy(64, lat);
    exp = model_valid(to_mm(500));
    vectors++; if (lat < 0 || Ultra_Dat !== 16'(exp)) begin miscompares++; $display("FAIL endrop_dat: got %0d expected %0d", Ultra_Dat, exp); end
    rises = 0;
    for (int i = 0; i < (PERIOD_US + 100) * CLK_MHZ; i++) begin
      @(negedge CLK);
      if (TRIG === 1'b1) rises++;
    end
    vectors++; if (rises != 0) begin miscompares++; $display("FAIL endrop_park: got %0d trig cycles expected 0", rises); end
  endtask

  task automatic test_reset_mid_trig;
    bit ok;
    int at, w, lat, exp;
    En = 1'b1;
    @(negedge CLK);
    vectors++; if (TRIG !== 1'b1) begin miscompares++; $display("FAIL restart_trig: got %b expected 1", TRIG); end
    tick(5);
    RST = 1'b1;
    #1;
    vectors++; if (TRIG !== 1'b0) begin miscompares++; $display("FAIL async_trig: got %b expected 0", TRIG); end
    vectors++; if (Ultra_Dat !== 16'h0000 || Ultra_Rdy !== 1'b0 || Ultra_Err !== 1'b0) begin miscompares++; $display("FAIL async_outputs: got %h/%b/%b expected 0000/0/0", Ultra_Dat, Ultra_Rdy, Ultra_Err); end
    @(negedge CLK);
    En = 1'b0;
    RST = 1'b0;
    hist.delete();
    tick(4);
    En = 1'b1;
    wait_trig_rise(ok, at);
    wait_trig_fall(w);
    echo_pulse(50, 1000, lat);
    exp = model_valid(to_mm(1000));
    vectors++; if (lat < 0 || Ultra_Dat !== 16'(exp) || Ultra_Err !== 1'b0) begin miscompares++; $display("FAIL post_reset: got %0d/%b expected %0d/0", Ultra_Dat, Ultra_Err, exp); end
    En = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_timeout();
    test_stuck_high();
    test_random();
    test_en_drop();
    test_reset_mid_trig();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
